// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memory ports.
interface multicycle_control_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Per-instruction state machine for the multi-cycle RV32IM core: sequences
// fetch/decode/execute/memory/writeback, waits on memory handshakes and on
// the iterative multiply/divide unit, and emits one-cycle write strobes.
module multicycle_control #(
  parameter int EN_M       = 1,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_if.master        mem,
  input  logic [31:0]                 instr,
  input  logic                        beq,
  input  logic                        blt,
  input  logic                        bltu,
  output logic                        ir_we,
  output logic                        pc_we,
  output logic                        rf_we,
  output logic [1:0]                  npc_op,
  output logic [1:0]                  wd_sel,
  output logic                        wb_pc_sel,
  output logic [2:0]                  sext_op,
  output logic [4:0]                  alu_op,
  output logic                        asel,
  output logic [1:0]                  store_sel,
  output logic [2:0]                  load_sel,
  output logic                        md_start,
  output logic                        illegal,
  output logic                        halted,
  output logic [2:0]                  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    TRAP   = 3'b101,
    HALT   = 3'b110
  } state_t;

  typedef enum logic [3:0] {
    K_ALU, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_MUL, K_DIV
  } kind_t;

  localparam logic [5:0] MD_MUL = 6'(MUL_CYCLES);
  localparam logic [5:0] MD_DIV = 6'(DIV_CYCLES);

  state_t      cur_state, next_state;
  kind_t       kind_q, dec_kind;
  logic [2:0]  sext_q, dec_sext;
  logic [4:0]  alu_q, dec_alu;
  logic        asel_q, dec_asel;
  logic [1:0]  wd_q, dec_wd;
  logic [1:0]  store_q, dec_store;
  logic [2:0]  load_q, dec_load;
  logic        dec_legal;
  logic [5:0]  md_cnt;

  logic imem_req_c, ir_we_c, pc_we_c, rf_we_c, dmem_req_c, dmem_we_c, md_start_c;
  logic [1:0] npc_op_c;
  logic wb_pc_sel_c;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register numbers are routed to the datapath directly; the controller ignores them.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // Shared ALU code for R-type and OP-IMM; alt selects sub/sra.
  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_alu = alt ? 5'b00001 : 5'b00000;
      3'b001:  base_alu = 5'b00010;
      3'b010:  base_alu = 5'b00011;
      3'b011:  base_alu = 5'b00100;
      3'b100:  base_alu = 5'b00101;
      3'b101:  base_alu = alt ? 5'b00111 : 5'b00110;
      3'b110:  base_alu = 5'b01000;
      default: base_alu = 5'b01001;
    endcase
  endfunction

  // Combinational instruction decode; only sampled while in DECODE.
  always_comb begin
    dec_kind  = K_ALU;
    dec_sext  = 3'b000;
    dec_alu   = 5'b00000;
    dec_asel  = 1'b0;
    dec_wd    = 2'b00;
    dec_store = 2'b00;
    dec_load  = 3'b000;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          dec_alu = base_alu(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_alu = base_alu(funct3, 1'b1);
        end else if (funct7 == 7'b0000001 && EN_M != 0) begin
          dec_alu  = 5'd13 + {2'b00, funct3};
          dec_kind = funct3[2] ? K_DIV : K_MUL;
        end else begin
          dec_legal = 1'b0;
        end
      end
      7'b0010011: begin
        dec_asel = 1'b1;
        if (funct3 == 3'b001) begin
          dec_sext  = 3'b001;
          dec_alu   = 5'b00010;
          dec_legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_sext  = 3'b001;
          dec_alu   = base_alu(funct3, funct7[5]);
          dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end else begin
          dec_alu = base_alu(funct3, 1'b0);
        end
      end
      7'b0000011: begin
        dec_kind = K_LOAD;
        dec_asel = 1'b1;
        dec_wd   = 2'b01;
        case (funct3)
          3'b010:  dec_load = 3'b000;
          3'b001:  dec_load = 3'b001;
          3'b000:  dec_load = 3'b010;
          3'b101:  dec_load = 3'b011;
          3'b100:  dec_load = 3'b100;
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        dec_kind = K_STORE;
        dec_sext = 3'b010;
        dec_asel = 1'b1;
        case (funct3)
          3'b010:  dec_store = 2'b00;
          3'b001:  dec_store = 2'b01;
          3'b000:  dec_store = 2'b10;
          default: dec_legal = 1'b0;
        endcase
      end
      7'b1100011: begin
        dec_kind  = K_BRANCH;
        dec_sext  = 3'b100;
        dec_alu   = 5'b00001;
        dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      7'b1101111: begin
        dec_kind = K_JAL;
        dec_sext = 3'b101;
        dec_wd   = 2'b10;
      end
      7'b1100111: begin
        dec_kind  = K_JALR;
        dec_asel  = 1'b1;
        dec_wd    = 2'b10;
        dec_legal = (funct3 == 3'b000);
      end
      7'b0110111: begin
        dec_kind = K_LUI;
        dec_sext = 3'b011;
        dec_alu  = 5'b01010;
        dec_asel = 1'b1;
        dec_wd   = 2'b11;
      end
      7'b0010111: begin
        dec_kind = K_AUIPC;
        dec_sext = 3'b011;
        dec_asel = 1'b1;
        dec_wd   = 2'b10;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur_state <= FETCH;
    else     cur_state <= next_state;
  end

  // Capture decoded controls in DECODE and hold them until the next decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q  <= K_ALU;
      sext_q  <= 3'b000;
      alu_q   <= 5'b00000;
      asel_q  <= 1'b0;
      wd_q    <= 2'b00;
      store_q <= 2'b00;
      load_q  <= 3'b000;
    end else if (cur_state == DECODE) begin
      kind_q  <= dec_kind;
      sext_q  <= dec_sext;
      alu_q   <= dec_alu;
      asel_q  <= dec_asel;
      wd_q    <= dec_wd;
      store_q <= dec_store;
      load_q  <= dec_load;
    end
  end

  // Multiply/divide countdown: loaded at decode, one tick per EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= 6'd0;
    end else if (cur_state == DECODE) begin
      md_cnt <= (dec_kind == K_MUL) ? MD_MUL : (dec_kind == K_DIV) ? MD_DIV : 6'd0;
    end else if (cur_state == EXEC && md_cnt != 6'd0) begin
      md_cnt <= md_cnt - 6'd1;
    end
  end

  // Next-state and strobe generation.
  always_comb begin
    next_state  = cur_state;
    imem_req_c  = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    rf_we_c     = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    md_start_c  = 1'b0;
    npc_op_c    = 2'b00;
    wb_pc_sel_c = 1'b0;
    case (cur_state)
      FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ready) begin
          ir_we_c    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (instr == 32'h0)  next_state = HALT;
        else if (!dec_legal) next_state = TRAP;
        else                 next_state = EXEC;
      end
      EXEC: begin
        case (kind_q)
          K_MUL, K_DIV: begin
            md_start_c = (md_cnt == ((kind_q == K_MUL) ? MD_MUL : MD_DIV));
            if (md_cnt <= 6'd1) next_state = WB;
          end
          K_LOAD, K_STORE: next_state = MEM;
          K_BRANCH: begin
            pc_we_c = 1'b1;
            case (funct3)
              3'b000:  npc_op_c = beq   ? 2'b01 : 2'b00;
              3'b001:  npc_op_c = !beq  ? 2'b01 : 2'b00;
              3'b100:  npc_op_c = blt   ? 2'b01 : 2'b00;
              3'b101:  npc_op_c = !blt  ? 2'b01 : 2'b00;
              3'b110:  npc_op_c = bltu  ? 2'b01 : 2'b00;
              3'b111:  npc_op_c = !bltu ? 2'b01 : 2'b00;
              default: npc_op_c = 2'b00;
            endcase
            next_state = FETCH;
          end
          default: next_state = WB;
        endcase
      end
      MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (kind_q == K_STORE);
        if (mem.dmem_ready) begin
          if (kind_q == K_STORE) begin
            pc_we_c    = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end
      end
      WB: begin
        rf_we_c     = 1'b1;
        pc_we_c     = 1'b1;
        npc_op_c    = (kind_q == K_JAL) ? 2'b01 : (kind_q == K_JALR) ? 2'b10 : 2'b00;
        wb_pc_sel_c = (kind_q == K_AUIPC);
        next_state  = FETCH;
      end
      TRAP:    next_state = TRAP;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  // A reset cycle aborts the instruction, so every strobe is masked while rst is high.
  assign mem.imem_req = imem_req_c & ~rst;
  assign mem.dmem_req = dmem_req_c & ~rst;
  assign mem.dmem_we  = dmem_we_c  & ~rst;
  assign ir_we        = ir_we_c    & ~rst;
  assign pc_we        = pc_we_c    & ~rst;
  assign rf_we        = rf_we_c    & ~rst;
  assign md_start     = md_start_c & ~rst;
  assign npc_op       = npc_op_c;
  assign wb_pc_sel    = wb_pc_sel_c;
  assign wd_sel       = wd_q;
  assign sext_op      = sext_q;
  assign alu_op       = alu_q;
  assign asel         = asel_q;
  assign store_sel    = store_q;
  assign load_sel     = load_q;
  assign illegal      = (cur_state == TRAP);
  assign halted       = (cur_state == HALT);
  assign state        = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a decode table plus per-instruction
// timing runs and hand-built trap/halt/reset sequences.
module tb_multicycle_control;

  localparam logic [2:0] S_FETCH = 3'b000, S_DECODE = 3'b001, S_EXEC = 3'b010,
                         S_MEM = 3'b011, S_WB = 3'b100, S_TRAP = 3'b101, S_HALT = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic beq = 1'b0, blt = 1'b0, bltu = 1'b0;

  multicycle_control_if mif1();
  multicycle_control_if mif0();
  assign mif1.imem_ready = imem_ready;
  assign mif1.dmem_ready = dmem_ready;
  assign mif0.imem_ready = imem_ready;
  assign mif0.dmem_ready = dmem_ready;

  logic ir_we, pc_we, rf_we, wb_pc_sel, asel, md_start, illegal, halted;
  logic [1:0] npc_op, wd_sel, store_sel;
  logic [2:0] sext_op, load_sel, state;
  logic [4:0] alu_op;

  logic ir_we0, pc_we0, rf_we0, wb_pc_sel0, asel0, md_start0, illegal0, halted0;
  logic [1:0] npc_op0, wd_sel0, store_sel0;
  logic [2:0] sext_op0, load_sel0, state0;
  logic [4:0] alu_op0;

  multicycle_control #(.EN_M(1), .MUL_CYCLES(3), .DIV_CYCLES(33)) dut (
    .clk(clk), .rst(rst), .mem(mif1), .instr(instr), .beq(beq), .blt(blt), .bltu(bltu),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .npc_op(npc_op), .wd_sel(wd_sel),
    .wb_pc_sel(wb_pc_sel), .sext_op(sext_op), .alu_op(alu_op), .asel(asel),
    .store_sel(store_sel), .load_sel(load_sel), .md_start(md_start),
    .illegal(illegal), .halted(halted), .state(state)
  );

  multicycle_control #(.EN_M(0), .MUL_CYCLES(3), .DIV_CYCLES(33)) dut_nom (
    .clk(clk), .rst(rst), .mem(mif0), .instr(instr), .beq(beq), .blt(blt), .bltu(bltu),
    .ir_we(ir_we0), .pc_we(pc_we0), .rf_we(rf_we0), .npc_op(npc_op0), .wd_sel(wd_sel0),
    .wb_pc_sel(wb_pc_sel0), .sext_op(sext_op0), .alu_op(alu_op0), .asel(asel0),
    .store_sel(store_sel0), .load_sel(load_sel0), .md_start(md_start0),
    .illegal(illegal0), .halted(halted0), .state(state0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  exp_state;
    logic [2:0]  exp_sext;
    logic [4:0]  exp_alu;
    logic        exp_asel;
    logic [1:0]  exp_wd;
    logic [1:0]  exp_store;
    logic [2:0]  exp_load;
  } dec_vec_t;

  localparam int NV = 27;
  dec_vec_t vecs[NV];

  // Results of the most recent runInstr.
  int lat, pc_cnt, rf_cnt, ir_cnt, md_cnt, dreq_cnt, dwe_cnt, exec_cnt, overlap_cnt;
  logic [1:0] npc_at_pc, wd_at_pc;
  logic wbpc_at_pc, rf_with_pc;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic iready, input logic dready,
                               input logic c_beq, input logic c_blt, input logic c_bltu);
    instr      = ins;
    imem_ready = iready;
    dmem_ready = dready;
    beq        = c_beq;
    blt        = c_blt;
    bltu       = c_bltu;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic runInstr(input logic [31:0] ins, input int imem_delay, input int dmem_delay,
                          input logic c_beq, input logic c_blt, input logic c_bltu);
    int  mem_wait;
    bit  done;
    doReset();
    lat = 0; pc_cnt = 0; rf_cnt = 0; ir_cnt = 0; md_cnt = 0; dreq_cnt = 0; dwe_cnt = 0;
    exec_cnt = 0; overlap_cnt = 0; npc_at_pc = 2'b11; wd_at_pc = 2'b00;
    wbpc_at_pc = 1'b0; rf_with_pc = 1'b0;
    mem_wait = 0;
    done = 1'b0;
    for (int c = 1; c <= 120 && !done; c++) begin
      applyStimulus(ins, (c == imem_delay + 1), (state == S_MEM && mem_wait == dmem_delay),
                    c_beq, c_blt, c_bltu);
      if (state == S_MEM) mem_wait++;
      @(negedge clk);
      if (pc_we) begin
        if (lat == 0) begin
          lat        = c;
          npc_at_pc  = npc_op;
          wd_at_pc   = wd_sel;
          wbpc_at_pc = wb_pc_sel;
          rf_with_pc = rf_we;
        end
        done = 1'b1;
      end
      pc_cnt      += int'(pc_we);
      rf_cnt      += int'(rf_we);
      ir_cnt      += int'(ir_we);
      md_cnt      += int'(md_start);
      dreq_cnt    += int'(mif1.dmem_req);
      dwe_cnt     += int'(mif1.dmem_we);
      exec_cnt    += int'(state == S_EXEC);
      overlap_cnt += int'(pc_we && ir_we);
      nextCycle();
    end
    // Two idle cycles after retirement must not produce further strobes.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(ins, 1'b0, 1'b0, c_beq, c_blt, c_bltu);
      @(negedge clk);
      pc_cnt += int'(pc_we);
      rf_cnt += int'(rf_we);
      nextCycle();
    end
  endtask

  task automatic checkRun(input string name, input int e_lat, input int e_rf, input logic [1:0] e_npc,
                          input logic [1:0] e_wd, input logic e_wbpc, input int e_md,
                          input int e_dreq, input int e_dwe, input int e_exec);
    checkOutput({name, " latency"}, lat, e_lat);
    checkOutput({name, " pc_we pulses"}, pc_cnt, 1);
    checkOutput({name, " ir_we pulses"}, ir_cnt, 1);
    checkOutput({name, " pc/ir overlap"}, overlap_cnt, 0);
    checkOutput({name, " rf_we pulses"}, rf_cnt, e_rf);
    checkOutput({name, " rf_we with pc_we"}, rf_with_pc, (e_rf != 0));
    checkOutput({name, " npc_op"}, npc_at_pc, e_npc);
    checkOutput({name, " wd_sel"}, wd_at_pc, e_wd);
    checkOutput({name, " wb_pc_sel"}, wbpc_at_pc, e_wbpc);
    checkOutput({name, " md_start pulses"}, md_cnt, e_md);
    checkOutput({name, " dmem_req cycles"}, dreq_cnt, e_dreq);
    checkOutput({name, " dmem_we cycles"}, dwe_cnt, e_dwe);
    checkOutput({name, " exec cycles"}, exec_cnt, e_exec);
  endtask

  initial begin
    int strobes;
    // {instr, state after decode, sext_op, alu_op, asel, wd_sel, store_sel, load_sel}
    vecs[0]  = '{32'h00500093, S_EXEC, 3'b000, 5'b00000, 1'b1, 2'b00, 2'b00, 3'b000}; // addi
    vecs[1]  = '{32'h402081B3, S_EXEC, 3'b000, 5'b00001, 1'b0, 2'b00, 2'b00, 3'b000}; // sub
    vecs[2]  = '{32'h00309093, S_EXEC, 3'b001, 5'b00010, 1'b1, 2'b00, 2'b00, 3'b000}; // slli
    vecs[3]  = '{32'h4030D093, S_EXEC, 3'b001, 5'b00111, 1'b1, 2'b00, 2'b00, 3'b000}; // srai
    vecs[4]  = '{32'h000011B7, S_EXEC, 3'b011, 5'b01010, 1'b1, 2'b11, 2'b00, 3'b000}; // lui
    vecs[5]  = '{32'h00001197, S_EXEC, 3'b011, 5'b00000, 1'b1, 2'b10, 2'b00, 3'b000}; // auipc
    vecs[6]  = '{32'h0000A103, S_EXEC, 3'b000, 5'b00000, 1'b1, 2'b01, 2'b00, 3'b000}; // lw
    vecs[7]  = '{32'h00008103, S_EXEC, 3'b000, 5'b00000, 1'b1, 2'b01, 2'b00, 3'b010}; // lb
    vecs[8]  = '{32'h0000D103, S_EXEC, 3'b000, 5'b00000, 1'b1, 2'b01, 2'b00, 3'b011}; // lhu
    vecs[9]  = '{32'h0020A223, S_EXEC, 3'b010, 5'b00000, 1'b1, 2'b00, 2'b00, 3'b000}; // sw
    vecs[10] = '{32'h00208223, S_EXEC, 3'b010, 5'b00000, 1'b1, 2'b00, 2'b10, 3'b000}; // sb
    vecs[11] = '{32'h00209223, S_EXEC, 3'b010, 5'b00000, 1'b1, 2'b00, 2'b01, 3'b000}; // sh
    vecs[12] = '{32'h00208463, S_EXEC, 3'b100, 5'b00001, 1'b0, 2'b00, 2'b00, 3'b000}; // beq
    vecs[13] = '{32'h010000EF, S_EXEC, 3'b101, 5'b00000, 1'b0, 2'b10, 2'b00, 3'b000}; // jal
    vecs[14] = '{32'h000100E7, S_EXEC, 3'b000, 5'b00000, 1'b1, 2'b10, 2'b00, 3'b000}; // jalr
    vecs[15] = '{32'h02208033, S_EXEC, 3'b000, 5'b01101, 1'b0, 2'b00, 2'b00, 3'b000}; // mul
    vecs[16] = '{32'h0220A033, S_EXEC, 3'b000, 5'b01111, 1'b0, 2'b00, 2'b00, 3'b000}; // mulhsu
    vecs[17] = '{32'h0220F033, S_EXEC, 3'b000, 5'b10100, 1'b0, 2'b00, 2'b00, 3'b000}; // remu
    vecs[18] = '{32'h40309093, S_TRAP, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // slli bad funct7
    vecs[19] = '{32'h0000B103, S_TRAP, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // load funct3 011
    vecs[20] = '{32'h0020B223, S_TRAP, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // store funct3 011
    vecs[21] = '{32'h0020A463, S_TRAP, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // branch funct3 010
    vecs[22] = '{32'h0000007F, S_TRAP, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // unknown opcode
    vecs[23] = '{32'h000110E7, S_TRAP, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // jalr funct3 001
    vecs[24] = '{32'h04208033, S_TRAP, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // R funct7 0000010
    vecs[25] = '{32'h40209033, S_TRAP, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // sll with alt bit
    vecs[26] = '{32'h00000000, S_HALT, 3'b000, 5'b00000, 1'b0, 2'b00, 2'b00, 3'b000}; // halt

    $display("[TB] reset state");
    rst = 1'b1;
    applyStimulus(32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset state", state, S_FETCH);
    checkOutput("reset state nom", state0, S_FETCH);
    checkOutput("reset imem_req", mif1.imem_req, 1'b0);
    checkOutput("reset ir_we", ir_we, 1'b0);
    checkOutput("reset pc_we", pc_we, 1'b0);
    checkOutput("reset rf_we", rf_we, 1'b0);
    checkOutput("reset dmem_req", mif1.dmem_req, 1'b0);
    checkOutput("reset md_start", md_start, 1'b0);
    checkOutput("reset illegal", illegal, 1'b0);
    checkOutput("reset halted", halted, 1'b0);
    checkOutput("reset selects", {sext_op, alu_op, asel, wd_sel, store_sel, load_sel, npc_op},
                32'h0);

    $display("[TB] decode table");
    for (int i = 0; i < NV; i++) begin
      doReset();
      applyStimulus(vecs[i].ins, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("vec%0d state", i), state, vecs[i].exp_state);
      if (vecs[i].exp_state == S_EXEC) begin
        checkOutput($sformatf("vec%0d sext_op", i), sext_op, vecs[i].exp_sext);
        checkOutput($sformatf("vec%0d alu_op", i), alu_op, vecs[i].exp_alu);
        checkOutput($sformatf("vec%0d asel", i), asel, vecs[i].exp_asel);
        checkOutput($sformatf("vec%0d wd_sel", i), wd_sel, vecs[i].exp_wd);
        checkOutput($sformatf("vec%0d store_sel", i), store_sel, vecs[i].exp_store);
        checkOutput($sformatf("vec%0d load_sel", i), load_sel, vecs[i].exp_load);
      end else begin
        checkOutput($sformatf("vec%0d illegal", i), illegal, vecs[i].exp_state == S_TRAP);
        checkOutput($sformatf("vec%0d halted", i), halted, vecs[i].exp_state == S_HALT);
      end
    end

    $display("[TB] timing runs");
    //      instr          imem dmem beq blt bltu   name        lat rf npc    wd     wbpc md dreq dwe exec
    runInstr(32'h00500093, 0, 0, 0, 0, 0); checkRun("addi",       4, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    runInstr(32'h00500093, 2, 0, 0, 0, 0); checkRun("addi slow",  6, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    runInstr(32'h0000A103, 0, 3, 0, 0, 0); checkRun("lw slow",    8, 1, 2'b00, 2'b01, 0, 0, 4, 0, 1);
    runInstr(32'h0000A103, 0, 0, 0, 0, 0); checkRun("lw",         5, 1, 2'b00, 2'b01, 0, 0, 1, 0, 1);
    runInstr(32'h0020A223, 0, 0, 0, 0, 0); checkRun("sw",         4, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1);
    runInstr(32'h0020A223, 0, 2, 0, 0, 0); checkRun("sw slow",    6, 0, 2'b00, 2'b00, 0, 0, 3, 3, 1);
    runInstr(32'h00208463, 0, 0, 1, 0, 0); checkRun("beq taken",  3, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1);
    runInstr(32'h00209463, 0, 0, 1, 0, 0); checkRun("bne nt",     3, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    runInstr(32'h0020C463, 0, 0, 0, 0, 1); checkRun("blt nt",     3, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    runInstr(32'h0020D463, 0, 0, 0, 0, 1); checkRun("bge taken",  3, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1);
    runInstr(32'h0020E463, 0, 0, 0, 1, 1); checkRun("bltu taken", 3, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1);
    runInstr(32'h0020F463, 0, 0, 0, 0, 1); checkRun("bgeu nt",    3, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    runInstr(32'h010000EF, 0, 0, 0, 0, 0); checkRun("jal",        4, 1, 2'b01, 2'b10, 0, 0, 0, 0, 1);
    runInstr(32'h000100E7, 0, 0, 0, 0, 0); checkRun("jalr",       4, 1, 2'b10, 2'b10, 0, 0, 0, 0, 1);
    runInstr(32'h00001197, 0, 0, 0, 0, 0); checkRun("auipc",      4, 1, 2'b00, 2'b10, 1, 0, 0, 0, 1);
    runInstr(32'h000011B7, 0, 0, 0, 0, 0); checkRun("lui",        4, 1, 2'b00, 2'b11, 0, 0, 0, 0, 1);
    runInstr(32'h02208033, 0, 0, 0, 0, 0); checkRun("mul",        6, 1, 2'b00, 2'b00, 0, 1, 0, 0, 3);
    runInstr(32'h0220C033, 0, 0, 0, 0, 0); checkRun("div",       36, 1, 2'b00, 2'b00, 0, 1, 0, 0, 33);
    runInstr(32'h0220F033, 0, 0, 0, 0, 0); checkRun("remu",      36, 1, 2'b00, 2'b00, 0, 1, 0, 0, 33);

    $display("[TB] M op without M extension");
    doReset();
    applyStimulus(32'h02208033, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("nom state trap", state0, S_TRAP);
    checkOutput("nom illegal", illegal0, 1'b1);
    checkOutput("withm state exec", state, S_EXEC);
    checkOutput("withm md_start", md_start, 1'b1);
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      @(negedge clk);
      strobes += int'(mif0.imem_req) + int'(ir_we0) + int'(pc_we0) + int'(rf_we0) + int'(md_start0);
    end
    checkOutput("nom trap strobes", strobes, 0);
    checkOutput("nom illegal sticky", illegal0, 1'b1);
    checkOutput("nom state sticky", state0, S_TRAP);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("nom after reset state", state0, S_FETCH);
    checkOutput("nom after reset illegal", illegal0, 1'b0);

    $display("[TB] halt");
    doReset();
    applyStimulus(32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("halt state", state, S_HALT);
    checkOutput("halt flag", halted, 1'b1);
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      @(negedge clk);
      strobes += int'(mif1.imem_req) + int'(pc_we) + int'(rf_we) + int'(ir_we);
    end
    checkOutput("halt no strobes", strobes, 0);
    checkOutput("halt sticky", halted, 1'b1);

    $display("[TB] reset during store MEM");
    doReset();
    applyStimulus(32'h0020A223, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("store mem state", state, S_MEM);
    checkOutput("store mem dmem_we", mif1.dmem_we, 1'b1);
    checkOutput("store mem pc_we", pc_we, 1'b0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(32'h0020A223, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst mem dmem_we", mif1.dmem_we, 1'b0);
    checkOutput("rst mem dmem_req", mif1.dmem_req, 1'b0);
    checkOutput("rst mem pc_we", pc_we, 1'b0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(32'h0020A223, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("after rst state", state, S_FETCH);
    checkOutput("after rst dmem_we", mif1.dmem_we, 1'b0);
    checkOutput("after rst pc_we", pc_we, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
